// File: rtl/a2_regfile_write_arbiter_pkg.sv
// Shared sizing constants and requester encoding for the register-file write arbiter.
package a2_regfile_write_arbiter_pkg;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int DW   = 8;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_e;

endpackage

// File: rtl/a2_regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: at most one grant per cycle, the pointer only
// advances when both sides contend, so a lone requester never disturbs fairness.
module a2_rr_arbiter2
  import a2_regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  req_idx_e r_ptr;
  req_idx_e w_ptr_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= REQ_ALU;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  always_comb begin
    grant      = 2'b00;
    w_ptr_next = r_ptr;
    unique case (valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (r_ptr == REQ_ALU) begin
          grant      = 2'b01;
          w_ptr_next = REQ_MEM;
        end else begin
          grant      = 2'b10;
          w_ptr_next = REQ_ALU;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/a2_regfile_write_arbiter.sv
// Single write-port controller for the 8x8 register file: round-robin writeback
// arbitration, registered write port, and a busy scoreboard that stalls issue.
module a2_regfile_write_arbiter
  import a2_regfile_write_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_rd,
  input  logic [DW-1:0]   req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_rd,
  input  logic [DW-1:0]   req1_data,
  output logic            req1_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_writes,
  output logic            stall,
  output logic            rf_WriteReg,
  output logic [AW-1:0]   rf_rd,
  output logic [DW-1:0]   rf_write_data,
  output logic [NREG-1:0] busy_mask
);

  logic [1:0]      w_grant;
  logic            w_any_grant;
  logic [AW-1:0]   w_win_rd;
  logic [DW-1:0]   w_win_data;
  logic            w_issue_set;
  logic [NREG-1:0] w_busy_next;

  logic            r_wr_en;
  logic [AW-1:0]   r_rd;
  logic [DW-1:0]   r_data;
  logic [NREG-1:0] r_busy;

  a2_rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid ({req1_valid, req0_valid}),
    .grant (w_grant)
  );

  assign req0_ready  = w_grant[REQ_ALU];
  assign req1_ready  = w_grant[REQ_MEM];
  assign w_any_grant = |w_grant;
  assign w_win_rd    = w_grant[REQ_MEM] ? req1_rd   : req0_rd;
  assign w_win_data  = w_grant[REQ_MEM] ? req1_data : req0_data;

  // Registered busy only: a grant clearing a source this cycle still stalls.
  assign stall = issue_valid &&
                 (r_busy[issue_rs1] || r_busy[issue_rs2] ||
                  (issue_writes && r_busy[issue_rd]));

  assign w_issue_set = issue_valid && issue_writes && !stall;

  always_comb begin
    w_busy_next = r_busy;
    if (w_any_grant) begin
      w_busy_next[w_win_rd] = 1'b0;
    end
    if (w_issue_set) begin
      w_busy_next[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
      r_busy  <= '0;
    end else begin
      r_wr_en <= w_any_grant;
      r_busy  <= w_busy_next;
      if (w_any_grant) begin
        r_rd   <= w_win_rd;
        r_data <= w_win_data;
      end
    end
  end

  assign rf_WriteReg   = r_wr_en;
  assign rf_rd         = r_rd;
  assign rf_write_data = r_data;
  assign busy_mask     = r_busy;

endmodule

// File: tb/tb_a2_regfile_write_arbiter.sv
// Self-checking bench for the register-file write arbiter: directed scenarios
// plus randomized traffic against a behavioural scoreboard/arbitration model.
module tb_a2_regfile_write_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_rd, req1_rd;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       issue_valid, issue_writes;
  logic [2:0] issue_rs1, issue_rs2, issue_rd;
  logic       stall;
  logic       rf_WriteReg;
  logic [2:0] rf_rd;
  logic [7:0] rf_write_data;
  logic [7:0] busy_mask;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int  m_ptr;
  bit  m_busy [8];
  bit  m_we;
  int  m_rd;
  int  m_data;
  int  m_last_w;

  a2_regfile_write_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_rd       (req0_rd),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_rd       (req1_rd),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rd      (issue_rd),
    .issue_writes  (issue_writes),
    .stall         (stall),
    .rf_WriteReg   (rf_WriteReg),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .busy_mask     (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_winner();
    if (req0_valid && req1_valid) return m_ptr;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit m_stall();
    if (!issue_valid) return 1'b0;
    return m_busy[issue_rs1] || m_busy[issue_rs2] || (issue_writes && m_busy[issue_rd]);
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) m[i] = m_busy[i];
    return m;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    m_we = 1'b0;
    m_rd = 0;
    m_data = 0;
    m_last_w = -1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_writes = 0;
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    int w;
    bit s;
    w = m_winner();
    s = m_stall();
    @(posedge clk);
    if (w >= 0) begin
      m_we = 1'b1;
      if (w == 0) begin m_rd = req0_rd; m_data = req0_data; end
      else        begin m_rd = req1_rd; m_data = req1_data; end
      m_busy[m_rd] = 1'b0;
      if (req0_valid && req1_valid) m_ptr = 1 - m_ptr;
    end else begin
      m_we = 1'b0;
    end
    if (issue_valid && issue_writes && !s) m_busy[issue_rd] = 1'b1;
    m_last_w = w;
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    checks++; if (rf_WriteReg !== 1'b0) begin errors++; $display("FAIL por_we got=%0b exp=0", rf_WriteReg); end
    checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL por_busy got=%h exp=00", busy_mask); end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; issue_writes = 1; issue_rd = 3'(i); issue_rs1 = 4; issue_rs2 = 4;
      if (i == 3) begin req0_valid = 1; req0_rd = 5; req0_data = 8'hA5; end
      tick();
    end
    checks++; if (busy_mask !== 8'h0F) begin errors++; $display("FAIL rst_pre_busy got=%h exp=0f", busy_mask); end
    checks++; if (rf_WriteReg !== 1'b1) begin errors++; $display("FAIL rst_pre_we got=%0b exp=1", rf_WriteReg); end
    issue_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (rf_WriteReg !== 1'b0) begin errors++; $display("FAIL rst_async_we got=%0b exp=0", rf_WriteReg); end
    checks++; if (rf_rd !== 3'd0) begin errors++; $display("FAIL rst_async_rd got=%0d exp=0", rf_rd); end
    checks++; if (rf_write_data !== 8'h00) begin errors++; $display("FAIL rst_async_data got=%h exp=00", rf_write_data); end
    checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL rst_async_busy got=%h exp=00", busy_mask); end
    @(posedge clk);
    #1;
    checks++; if (rf_WriteReg !== 1'b0) begin errors++; $display("FAIL rst_hold_we got=%0b exp=0", rf_WriteReg); end
    reset = 1'b0;
    clear_inputs();
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_rd = 2; req0_data = 8'h20;
    #2;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got=%0b exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got=%0b exp=0", req1_ready); end
    tick();
    req0_valid = 0;
    checks++; if (rf_WriteReg !== 1'b1) begin errors++; $display("FAIL single_we got=%0b exp=1", rf_WriteReg); end
    checks++; if (rf_rd !== 3'd2) begin errors++; $display("FAIL single_rd got=%0d exp=2", rf_rd); end
    checks++; if (rf_write_data !== 8'h20) begin errors++; $display("FAIL single_data got=%h exp=20", rf_write_data); end
    tick();
    checks++; if (rf_WriteReg !== 1'b0) begin errors++; $display("FAIL single_idle_we got=%0b exp=0", rf_WriteReg); end
    checks++; if (rf_rd !== 3'd2) begin errors++; $display("FAIL single_hold_rd got=%0d exp=2", rf_rd); end
    // a lone requester holding valid is granted every cycle
    req1_valid = 1; req1_rd = 1; req1_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 cyc=%0d got=%0b exp=1", i, req1_ready); end
      tick();
      checks++; if (rf_WriteReg !== 1'b1) begin errors++; $display("FAIL b2b_we cyc=%0d got=%0b exp=1", i, rf_WriteReg); end
    end
    clear_inputs();
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1; req0_rd = 4; req0_data = 8'h30;
    req1_valid = 1; req1_rd = 6; req1_data = 8'h40;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (req0_ready !== (i % 2 == 0)) begin errors++; $display("FAIL cont_ready0 cyc=%0d got=%0b exp=%0b", i, req0_ready, (i % 2 == 0)); end
      checks++; if (req1_ready !== (i % 2 == 1)) begin errors++; $display("FAIL cont_ready1 cyc=%0d got=%0b exp=%0b", i, req1_ready, (i % 2 == 1)); end
      tick();
      checks++; if (rf_rd !== ((i % 2 == 0) ? 3'd4 : 3'd6)) begin errors++; $display("FAIL cont_rd cyc=%0d got=%0d exp=%0d", i, rf_rd, (i % 2 == 0) ? 4 : 6); end
      checks++; if (rf_write_data !== ((i % 2 == 0) ? 8'h30 : 8'h40)) begin errors++; $display("FAIL cont_data cyc=%0d got=%h", i, rf_write_data); end
    end
    clear_inputs();
  endtask

  task automatic test_raw();
    do_reset();
    issue_valid = 1; issue_writes = 1; issue_rd = 3; issue_rs1 = 0; issue_rs2 = 0;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got=%0b exp=0", stall); end
    tick();
    checks++; if (busy_mask !== 8'h08) begin errors++; $display("FAIL raw_busy_set got=%h exp=08", busy_mask); end
    issue_writes = 0; issue_rs1 = 3;
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall got=%0b exp=1", stall); end
    tick();
    req1_valid = 1; req1_rd = 3; req1_data = 8'h55;
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass got=%0b exp=1", stall); end
    tick();
    req1_valid = 0;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_release got=%0b exp=0", stall); end
    checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL raw_busy_clr got=%h exp=00", busy_mask); end
    checks++; if (rf_rd !== 3'd3 || rf_WriteReg !== 1'b1) begin errors++; $display("FAIL raw_write got=%0b/%0d exp=1/3", rf_WriteReg, rf_rd); end
    clear_inputs();
  endtask

  task automatic test_waw();
    do_reset();
    issue_valid = 1; issue_writes = 1; issue_rd = 5; issue_rs1 = 0; issue_rs2 = 0;
    tick();
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got=%0b exp=1", stall); end
    issue_writes = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_nowrite got=%0b exp=0", stall); end
    issue_writes = 1; issue_valid = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_invalid got=%0b exp=0", stall); end
    tick();
    checks++; if (busy_mask !== 8'h20) begin errors++; $display("FAIL waw_busy got=%h exp=20", busy_mask); end
    clear_inputs();
  endtask

  task automatic test_concurrent();
    do_reset();
    issue_valid = 1; issue_writes = 1; issue_rd = 7;
    tick();
    checks++; if (busy_mask !== 8'h80) begin errors++; $display("FAIL conc_pre got=%h exp=80", busy_mask); end
    issue_rd = 1;
    req0_valid = 1; req0_rd = 7; req0_data = 8'h77;
    tick();
    checks++; if (busy_mask !== 8'h02) begin errors++; $display("FAIL conc_busy got=%h exp=02", busy_mask); end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      if (!req0_valid || m_last_w == 0) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_rd = 3'($urandom_range(0, 7));
        req0_data = 8'($urandom);
      end
      if (!req1_valid || m_last_w == 1) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_rd = 3'($urandom_range(0, 7));
        req1_data = 8'($urandom);
      end
      issue_valid  = ($urandom_range(0, 1) == 1);
      issue_writes = ($urandom_range(0, 1) == 1);
      issue_rs1 = 3'($urandom_range(0, 7));
      issue_rs2 = 3'($urandom_range(0, 7));
      issue_rd  = 3'($urandom_range(0, 7));
      #2;
      checks++; if (req0_ready !== (m_winner() == 0)) begin errors++; $display("FAIL rnd_ready0 cyc=%0d got=%0b exp=%0b", c, req0_ready, (m_winner() == 0)); end
      checks++; if (req1_ready !== (m_winner() == 1)) begin errors++; $display("FAIL rnd_ready1 cyc=%0d got=%0b exp=%0b", c, req1_ready, (m_winner() == 1)); end
      checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", c, stall, m_stall()); end
      tick();
      checks++; if (rf_WriteReg !== m_we) begin errors++; $display("FAIL rnd_we cyc=%0d got=%0b exp=%0b", c, rf_WriteReg, m_we); end
      checks++; if (rf_rd !== 3'(m_rd) || rf_write_data !== 8'(m_data)) begin errors++; $display("FAIL rnd_port cyc=%0d got=%0d/%h exp=%0d/%h", c, rf_rd, rf_write_data, m_rd, m_data); end
      checks++; if (busy_mask !== m_mask()) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", c, busy_mask, m_mask()); end
      if (m_we) $display("txn cyc=%0d req%0d rd=%0d data=%h busy=%h", c, m_last_w, m_rd, m_data, m_mask());
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_contention();
    test_raw();
    test_waw();
    test_concurrent();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/a2_regfile_write_arbiter.md
Name: a2_regfile_write_arbiter

Overview:
Controller for the single write port of the 8 x 8 register file in the pipelined datapath. It arbitrates round-robin between two writeback requesters (req0 = ALU writeback, req1 = load/memory writeback) and drives the register file's WriteReg/rd/write_data as registered outputs. A per-register busy scoreboard tracks destinations with a write still pending, and stalls issue on RAW/WAW hazards against them.

Parameters:
NREG, 8, number of architectural registers (one busy bit each)
AW, 3, register address width (log2 NREG)
DW, 8, register data width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has a write pending
req0_rd  input  AW  requester 0 destination register
req0_data  input  DW  requester 0 write data
req0_ready  output  1  requester 0 granted this cycle (combinational)
req1_valid  input  1  requester 1 has a write pending
req1_rd  input  AW  requester 1 destination register
req1_data  input  DW  requester 1 write data
req1_ready  output  1  requester 1 granted this cycle (combinational)
issue_valid  input  1  issue stage presents an instruction
issue_rs1  input  AW  source register 1 of issuing instruction
issue_rs2  input  AW  source register 2 of issuing instruction
issue_rd  input  AW  destination of issuing instruction
issue_writes  input  1  issuing instruction will write issue_rd
stall  output  1  issue must hold (combinational from registered busy)
rf_WriteReg  output  1  write enable to register file (registered)
rf_rd  output  AW  write address to register file (registered)
rf_write_data  output  DW  write data to register file (registered)
busy_mask  output  NREG  current scoreboard, bit i = register i pending

Behaviour:
- Reset (async, active-high): rf_WriteReg=0, rf_rd=0, rf_write_data=0, busy_mask=0, round-robin pointer=0 (req0 favoured). Reset asserted mid-transfer discards any grant in progress and clears all busy bits; no write is emitted.
- Handshake: transfer occurs when reqN_valid && reqN_ready. Requesters hold rd/data stable while valid and not ready. ready depends only on valid inputs and the pointer, never on ready.
- Arbitration: exactly one grant per cycle max. Only one valid -> grant it regardless of pointer. Both valid -> grant the pointer side, then the pointer moves to the other side. No valid -> no grant, pointer unchanged. A single requester holding valid receives back-to-back grants every cycle.
- Write port: a grant in cycle N gives rf_WriteReg=1 with rf_rd/rf_write_data of the winner during cycle N+1 (latency 1). No grant in cycle N gives rf_WriteReg=0 in cycle N+1; rf_rd/rf_write_data hold their last values.
- Scoreboard set: on the clock edge where issue_valid && issue_writes && !stall, busy[issue_rd] <= 1.
- Scoreboard clear: on the edge of a grant, busy[winner rd] <= 0. A grant to a non-busy register is legal, clears nothing, and still writes.
- Same-edge set and clear of the same register cannot occur, because WAW stall blocks the set. Same-edge set and clear of different registers both take effect.
- stall = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || (issue_writes && busy[issue_rd])). It uses registered busy only, with no same-cycle bypass of a clearing grant. The minimum hazard penalty is therefore 1 cycle after the grant edge.
- stall=0 whenever issue_valid=0.

Decomposition:
- Shared package/header: NREG, AW, DW constants and requester index encoding (REQ_ALU=0, REQ_MEM=1).
- One natural sub-module: a2_rr_arbiter2, a 2-way round-robin arbiter with pointer flop, valid in and grant out. The scoreboard and write-port registers stay in the top module.

Test Plan:
- Reset: assert reset mid-cycle with busy_mask=8'h0F and rf_WriteReg=1 -> all outputs 0 immediately (async), busy_mask=8'h00.
- Single requester: req0_valid=1, rd=2, data=8'h20 for one cycle -> req0_ready=1 same cycle; next cycle rf_WriteReg=1, rf_rd=2, rf_write_data=8'h20; following cycle rf_WriteReg=0.
- Contention: both valid continuously (req0 rd=4/8'h30, req1 rd=6/8'h40) from reset -> grants alternate 0,1,0,1. rf_rd sequence is 4,6,4,6 one cycle later; neither requester waits more than 1 cycle.
- RAW stall: issue rd=3, writes=1 -> busy_mask=8'h08. Then issue rs1=3 -> stall=1 until the cycle after req1 granted with rd=3; stall=0 that cycle and busy_mask=8'h00.
- WAW stall: busy[5]=1, issue rd=5, writes=1, rs1=rs2=0 -> stall=1. With issue_writes=0 and the same sources -> stall=0.
- Concurrent: same edge issue sets rd=1 while grant clears rd=7 (busy_mask was 8'h80) -> busy_mask=8'h02.
